// File: rtl/systolic_psum_collector.sv
// Systolic-array partial-sum collector: per-lane K-pass accumulation into a tile buffer, then row drain.
// Optional saturating accumulate (adds sat_flag_o) when PSUM_COLLECT_SAT_EN is defined.

module systolic_psum_lane #(
   parameter int PSUM_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int TILE_ROWS  = 64,
   parameter int RW         = $clog2(TILE_ROWS)
) (
   input  logic                  s_clk,
   input  logic                  s_rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic                  first_i,
   input  logic                  valid_i,
   input  logic [PSUM_WIDTH-1:0] psum_i,
   input  logic [RW-1:0]         rd_addr_i,
   output logic [ACC_WIDTH-1:0]  rd_data_o,
   output logic                  done_o,
   output logic                  drop_o
`ifdef PSUM_COLLECT_SAT_EN
   ,
   output logic                  sat_o
`endif
);
   logic [ACC_WIDTH-1:0] mem_q [TILE_ROWS];
   logic [RW-1:0]        cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic [ACC_WIDTH-1:0] ext, cur, wr_val;

   assign accept    = valid_i && en_i && !done_q;
   assign drop_o    = valid_i && (!en_i || done_q);
   assign ext       = ACC_WIDTH'($signed(psum_i));
   assign cur       = mem_q[cnt_q];
   assign rd_data_o = mem_q[rd_addr_i];
   assign done_o    = done_q;

`ifdef PSUM_COLLECT_SAT_EN
   logic [ACC_WIDTH:0] sum;
   logic               ovf;
   // One guard bit: overflow when the two top bits of the widened sum disagree.
   assign sum   = {cur[ACC_WIDTH-1], cur} + {ext[ACC_WIDTH-1], ext};
   assign ovf   = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
   assign sat_o = accept && !first_i && ovf;
   always_comb begin
      wr_val = sum[ACC_WIDTH-1:0];
      if (first_i)
         wr_val = ext;
      else if (ovf)
         wr_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
   end
`else
   always_comb wr_val = first_i ? ext : cur + ext;
`endif

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (clr_i) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (accept) begin
         cnt_d = cnt_q + RW'(1);
         if (cnt_q == RW'(TILE_ROWS-1))
            done_d = 1'b1;
      end
   end

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   // Tile storage is deliberately left out of reset.
   always_ff @(posedge s_clk) begin
      if (accept)
         mem_q[cnt_q] <= wr_val;
   end
endmodule

module systolic_psum_collector #(
   parameter int UNIT_NUM   = 8,
   parameter int PSUM_WIDTH = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int TILE_ROWS  = 64
) (
   input  logic                           s_clk,
   input  logic                           s_rst,
   input  logic                           pass_start_i,
   input  logic                           pass_last_i,
   input  logic [UNIT_NUM-1:0]            psum_valid_i,
   input  logic [UNIT_NUM*PSUM_WIDTH-1:0] psum_data_i,
   output logic                           in_ready_o,
   output logic                           out_valid_o,
   output logic [UNIT_NUM*ACC_WIDTH-1:0]  out_data_o,
   output logic                           out_last_o,
   input  logic                           out_ready_i,
   output logic                           busy_o,
   output logic                           tile_done_o,
   output logic                           err_drop_o
`ifdef PSUM_COLLECT_SAT_EN
   ,
   output logic                           sat_flag_o
`endif
);
   localparam int RW = $clog2(TILE_ROWS);

   typedef enum logic [1:0] {IDLE, ACCUM, WAIT, DRAIN} state_t;

   state_t                             state_q, state_d;
   logic                               last_q, last_d, first_q, first_d;
   logic [RW-1:0]                      rd_q, rd_d;
   logic                               ov_q, ov_d, ol_q, ol_d, td_q, td_d, err_q, err_d;
   logic [UNIT_NUM-1:0][ACC_WIDTH-1:0] od_q, od_d, rd_row;
   logic [UNIT_NUM-1:0]                done, drop;
   logic                               clr, load, all_done;

   assign all_done = &done;

`ifdef PSUM_COLLECT_SAT_EN
   logic [UNIT_NUM-1:0] sat;
   logic                sat_q;
`endif

   for (genvar j = 0; j < UNIT_NUM; j++) begin : g_lane
      systolic_psum_lane #(
         .PSUM_WIDTH(PSUM_WIDTH), .ACC_WIDTH(ACC_WIDTH), .TILE_ROWS(TILE_ROWS), .RW(RW)
      ) u_lane (
         .s_clk    (s_clk),
         .s_rst    (s_rst),
         .clr_i    (clr),
         .en_i     (in_ready_o),
         .first_i  (first_q),
         .valid_i  (psum_valid_i[j]),
         .psum_i   (psum_data_i[j*PSUM_WIDTH +: PSUM_WIDTH]),
         .rd_addr_i(rd_q),
         .rd_data_o(rd_row[j]),
         .done_o   (done[j]),
         .drop_o   (drop[j])
`ifdef PSUM_COLLECT_SAT_EN
         ,
         .sat_o    (sat[j])
`endif
      );
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      first_d = first_q;
      rd_d    = rd_q;
      ov_d    = ov_q;
      ol_d    = ol_q;
      od_d    = od_q;
      td_d    = 1'b0;
      err_d   = err_q | (|drop);
      load    = 1'b0;
      case (state_q)
         IDLE: if (pass_start_i) begin
            state_d = ACCUM;
            first_d = 1'b1;
            last_d  = pass_last_i;
         end
         ACCUM: if (all_done) begin
            // Row 0 is loaded on the transition so out_valid is up in the first DRAIN cycle.
            if (last_q) begin
               state_d = DRAIN;
               load    = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: if (pass_start_i) begin
            state_d = ACCUM;
            first_d = 1'b0;
            last_d  = pass_last_i;
         end
         DRAIN: begin
            if (ov_q && out_ready_i && ol_q) begin
               state_d = IDLE;
               ov_d    = 1'b0;
               ol_d    = 1'b0;
               td_d    = 1'b1;
            end else if (!ov_q || out_ready_i) begin
               load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // rd wraps back to 0 after the last row, ready for the next tile.
      if (load) begin
         od_d = rd_row;
         ov_d = 1'b1;
         ol_d = (rd_q == RW'(TILE_ROWS-1));
         rd_d = rd_q + RW'(1);
      end
   end

   assign clr = (state_q != ACCUM) && (state_d == ACCUM);

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         first_q <= 1'b1;
         rd_q    <= '0;
         ov_q    <= 1'b0;
         ol_q    <= 1'b0;
         od_q    <= '0;
         td_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         first_q <= first_d;
         rd_q    <= rd_d;
         ov_q    <= ov_d;
         ol_q    <= ol_d;
         od_q    <= od_d;
         td_q    <= td_d;
         err_q   <= err_d;
      end
   end

`ifdef PSUM_COLLECT_SAT_EN
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) sat_q <= 1'b0;
      else       sat_q <= sat_q | (|sat);
   end
   assign sat_flag_o = sat_q;
`endif

   assign in_ready_o  = (state_q == ACCUM);
   assign busy_o      = (state_q != IDLE);
   assign out_valid_o = ov_q;
   assign out_last_o  = ol_q;
   assign out_data_o  = od_q;
   assign tile_done_o = td_q;
   assign err_drop_o  = err_q;
endmodule

// File: tb/tb_systolic_psum_collector.sv
// Scoreboard bench for systolic_psum_collector: directed passes push expected rows, a monitor pops on handshake.
module tb_systolic_psum_collector;
   localparam int UN = 4, PW = 16, AW = 20, TR = 4;

   logic           s_clk = 1'b0;
   logic           s_rst;
   logic           pass_start, pass_last, out_ready;
   logic [UN-1:0]  psum_valid;
   logic [UN*PW-1:0] psum_data;
   logic           in_ready, out_valid, out_last, busy, tile_done, err_drop;
   logic [UN*AW-1:0] out_data;
`ifdef PSUM_COLLECT_SAT_EN
   logic           sat_flag;
`endif

   systolic_psum_collector #(.UNIT_NUM(UN), .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .TILE_ROWS(TR)) dut (
      .s_clk(s_clk), .s_rst(s_rst),
      .pass_start_i(pass_start), .pass_last_i(pass_last),
      .psum_valid_i(psum_valid), .psum_data_i(psum_data),
      .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
      .out_last_o(out_last), .out_ready_i(out_ready), .busy_o(busy),
      .tile_done_o(tile_done), .err_drop_o(err_drop)
`ifdef PSUM_COLLECT_SAT_EN
      , .sat_flag_o(sat_flag)
`endif
   );

   always #5 s_clk = ~s_clk;

   typedef struct packed { logic [UN*AW-1:0] data; logic last; } row_t;
   row_t exp_q[$];
   int tests = 0, fails = 0, td_cnt = 0, hs_cnt = 0;
   logic [PW-1:0] pv [UN][TR];
   logic [AW-1:0] ev [UN][TR];

   task automatic chk(input string name, input logic [UN*AW-1:0] act, input logic [UN*AW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [UN*AW-1:0] row_of(input int r);
      logic [UN*AW-1:0] d;
      d = '0;
      for (int j = 0; j < UN; j++) d[j*AW +: AW] = ev[j][r];
      return d;
   endfunction

   task automatic push_exp();
      row_t e;
      for (int r = 0; r < TR; r++) begin
         e.data = row_of(r);
         e.last = (r == TR-1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: compare every accepted row against the scoreboard head.
   always @(negedge s_clk) begin
      row_t e;
      if (tile_done) td_cnt++;
      if (out_valid && out_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_row: got %h expected none", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("row_data", out_data, e.data);
            chk1("row_last", out_last, e.last);
         end
      end
   end

   // Entered and left at posedge+#1; returns right after the pass leaves ACCUM.
   task automatic run_pass(input logic last, input bit skew, input bit extra);
      pass_start = 1'b1;
      pass_last  = last;
      @(posedge s_clk); #1;
      pass_start = 1'b0;
      pass_last  = 1'b0;
      for (int t = 0; t <= (skew ? TR+UN-2 : TR-1); t++) begin
         psum_valid = '0;
         psum_data  = '0;
         for (int j = 0; j < UN; j++) begin
            int r;
            r = t - (skew ? j : 0);
            if (r >= 0 && r < TR) begin
               psum_valid[j] = 1'b1;
               psum_data[j*PW +: PW] = pv[j][r];
            end else if (extra && j == 2 && r == TR) begin
               psum_valid[j] = 1'b1;
               psum_data[j*PW +: PW] = 16'h03E7;
            end
         end
         @(posedge s_clk); #1;
      end
      psum_valid = '0;
      psum_data  = '0;
      for (int k = 0; k < 10 && in_ready; k++) begin
         @(posedge s_clk); #1;
      end
      chk1("pass_leaves_accum", in_ready, 1'b0);
   endtask

   task automatic wait_tile();
      int start;
      start = td_cnt;
      for (int k = 0; k < 60 && td_cnt == start; k++) begin
         @(posedge s_clk); #1;
      end
      repeat (2) begin
         @(posedge s_clk); #1;
      end
      chk_int("tile_done_pulses", td_cnt - start, 1);
      chk_int("handshakes", hs_cnt, TR);
      chk_int("rows_left", exp_q.size(), 0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_valid", out_valid, 1'b0);
   endtask

   task automatic chk_wait(input string name);
      chk1({name, "_busy"}, busy, 1'b1);
      chk1({name, "_in_ready"}, in_ready, 1'b0);
      chk1({name, "_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      s_rst = 1'b1; pass_start = 1'b0; pass_last = 1'b0;
      psum_valid = '0; psum_data = '0; out_ready = 1'b1;
      #12;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_tile_done", tile_done, 1'b0);
      chk1("rst_err_drop", err_drop, 1'b0);
      chk("rst_out_data", out_data, '0);
`ifdef PSUM_COLLECT_SAT_EN
      chk1("rst_sat_flag", sat_flag, 1'b0);
`endif
      @(posedge s_clk); #1;
      s_rst = 1'b0;

      // Single skewed pass, with 3 cycles of backpressure on row 1.
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) begin
            pv[j][r] = PW'(10*j + r);
            ev[j][r] = AW'(10*j + r);
         end
      push_exp();
      run_pass(1'b1, 1'b1, 1'b0);
      hs_cnt = 0;
      chk1("drain_first_valid", out_valid, 1'b1);
      @(posedge s_clk); #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge s_clk);
         chk1("bp_valid", out_valid, 1'b1);
         chk("bp_data", out_data, {20'd31, 20'd21, 20'd11, 20'd1});
         chk1("bp_last", out_last, 1'b0);
      end
      @(posedge s_clk); #1;
      out_ready = 1'b1;
      wait_tile();

      // Three passes of -5 each.
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) begin
            pv[j][r] = 16'hFFFB;
            ev[j][r] = 20'hFFFF1;
         end
      push_exp();
      run_pass(1'b0, 1'b0, 1'b0);
      chk_wait("wait1");
      run_pass(1'b0, 1'b0, 1'b0);
      chk_wait("wait2");
      run_pass(1'b1, 1'b0, 1'b0);
      hs_cnt = 0;
      wait_tile();

      // Drops: psum during WAIT, then an extra psum on lane 2 after it completed.
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) pv[j][r] = PW'(4*j + r + 1);
      run_pass(1'b0, 1'b1, 1'b0);
      chk_wait("wait3");
      chk1("err_clean", err_drop, 1'b0);
      psum_valid = 4'b0001;
      psum_data  = '0;
      psum_data[PW-1:0] = 16'h1111;
      @(posedge s_clk); #1;
      psum_valid = '0;
      psum_data  = '0;
      chk1("err_wait_drop", err_drop, 1'b1);
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) begin
            pv[j][r] = 16'd100;
            ev[j][r] = AW'(4*j + r + 101);
         end
      push_exp();
      run_pass(1'b1, 1'b1, 1'b1);
      hs_cnt = 0;
      chk1("err_sticky", err_drop, 1'b1);
      wait_tile();

      // 17 passes of 0x7FFF overflow the 20-bit accumulator on the last pass.
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) begin
            pv[j][r] = 16'h7FFF;
`ifdef PSUM_COLLECT_SAT_EN
            ev[j][r] = 20'h7FFFF;
`else
            ev[j][r] = 20'h87FEF;
`endif
         end
      push_exp();
      for (int p = 0; p < 17; p++) begin
         run_pass(p == 16, 1'b0, 1'b0);
`ifdef PSUM_COLLECT_SAT_EN
         if (p == 15) chk1("sat_before_ovf", sat_flag, 1'b0);
`endif
      end
      hs_cnt = 0;
      wait_tile();
`ifdef PSUM_COLLECT_SAT_EN
      chk1("sat_flag_set", sat_flag, 1'b1);
`endif

      // Reset while row 2 is presented, then a fresh overwrite pass of 1s.
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) begin
            pv[j][r] = 16'd7;
            ev[j][r] = 20'd7;
         end
      push_exp();
      run_pass(1'b1, 1'b0, 1'b0);
      hs_cnt = 0;
      @(posedge s_clk); #1;
      @(posedge s_clk); #1;
      out_ready = 1'b0;
      s_rst = 1'b1;
      #1;
      chk1("arst_valid", out_valid, 1'b0);
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_tile_done", tile_done, 1'b0);
      chk1("arst_err", err_drop, 1'b0);
      chk_int("arst_rows_accepted", hs_cnt, 2);
      chk_int("arst_rows_pending", exp_q.size(), 2);
      exp_q.delete();
      @(posedge s_clk); #1;
      s_rst = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < UN; j++)
         for (int r = 0; r < TR; r++) begin
            pv[j][r] = 16'd1;
            ev[j][r] = 20'd1;
         end
      push_exp();
      run_pass(1'b1, 1'b1, 1'b1);
      hs_cnt = 0;
      chk1("err_done_lane", err_drop, 1'b1);
      wait_tile();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
